// File: rtl/omsp_spm_ctrl_seq_pkg.sv
// Shared op codes, response error codes and scan FSM states for the
// sequential protected-module controller.
package omsp_spm_ctrl_seq_pkg;

  typedef enum logic {
    OP_CREATE  = 1'b0,
    OP_DESTROY = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_BAD_RANGE = 3'd1,
    ERR_OVERLAP   = 3'd2,
    ERR_FULL      = 3'd3,
    ERR_EXHAUST   = 3'd4,
    ERR_NOT_FOUND = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SCAN,
    ST_COMMIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/omsp_spm_ctrl_seq_slot.sv
// One protected-module slot: bounds and ID registers, pc match and
// overlap comparison against a candidate text/data range pair.
module omsp_spm_slot #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 16
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              wr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] new_ts,
  input  logic [ADDR_W-1:0] new_te,
  input  logic [ADDR_W-1:0] new_ds,
  input  logic [ADDR_W-1:0] new_de,
  input  logic [ID_W-1:0]   new_id,
  input  logic [ADDR_W-1:0] pc,
  output logic              enabled,
  output logic [ID_W-1:0]   id,
  output logic              hit,
  output logic              overlap
);

  logic [ADDR_W-1:0] ts, te, ds, de;

  function automatic logic ovl(input logic [ADDR_W-1:0] as, ae, bs, be);
    return (as < be) && (bs < ae);
  endfunction

  always_ff @(posedge mclk) begin
    if (puc_rst || clr) begin
      enabled <= 1'b0;
      id      <= '0;
      ts      <= '0;
      te      <= '0;
      ds      <= '0;
      de      <= '0;
    end else if (wr) begin
      enabled <= 1'b1;
      id      <= new_id;
      ts      <= new_ts;
      te      <= new_te;
      ds      <= new_ds;
      de      <= new_de;
    end
  end

  assign hit     = enabled && (pc >= ts) && (pc < te);
  // Either stored range against either candidate range.
  assign overlap = enabled && (ovl(ts, te, new_ts, new_te) || ovl(ts, te, new_ds, new_de) ||
                               ovl(ds, de, new_ts, new_te) || ovl(ds, de, new_ds, new_de));

endmodule

// File: rtl/omsp_spm_ctrl_seq.sv
// Sequential SM controller: slot table, command handshake, one-slot-per-cycle
// scan FSM, current/previous SM ID tracking and sticky violation flag.
module omsp_spm_ctrl_seq
  import omsp_spm_ctrl_seq_pkg::*;
#(
  parameter int NB_SM  = 4,
  parameter int ID_W   = 16,
  parameter int ADDR_W = 16
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] r12,
  input  logic [ADDR_W-1:0] r13,
  input  logic [ADDR_W-1:0] r14,
  input  logic [ADDR_W-1:0] r15,
  output logic              resp_valid,
  output logic [2:0]        resp_err,
  output logic [ID_W-1:0]   resp_id,
  input  logic [ADDR_W-1:0] pc,
  input  logic              handling_irq,
  output logic [ID_W-1:0]   spm_current_id,
  output logic [ID_W-1:0]   spm_prev_id,
  output logic              violation
);

  localparam int IDX_W = (NB_SM > 1) ? $clog2(NB_SM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SM - 1);
  localparam logic [ID_W-1:0]  ID_IRQ   = '1;

  state_e            state;
  op_e               op;
  err_e              err;
  logic [ID_W-1:0]   cid, rid, next_id, prev_cycle_id;
  logic [ADDR_W-1:0] ts, te, ds, de;
  logic [IDX_W-1:0]  idx, free_idx, found_idx;
  logic              free_found, found;

  logic              slot_en  [NB_SM];
  logic [ID_W-1:0]   slot_id  [NB_SM];
  logic              slot_hit [NB_SM];
  logic              slot_ovl [NB_SM];
  logic [NB_SM-1:0]  slot_wr, slot_clr;

  for (genvar i = 0; i < NB_SM; i++) begin : g_slot
    assign slot_wr[i]  = (state == ST_COMMIT) && (op == OP_CREATE) && (err != ERR_OVERLAP) &&
                         free_found && (free_idx == IDX_W'(i));
    assign slot_clr[i] = (state == ST_COMMIT) && (op == OP_DESTROY) && found &&
                         (found_idx == IDX_W'(i));

    omsp_spm_slot #(.ID_W(ID_W), .ADDR_W(ADDR_W)) u_slot (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .wr      (slot_wr[i]),
      .clr     (slot_clr[i]),
      .new_ts  (ts),
      .new_te  (te),
      .new_ds  (ds),
      .new_de  (de),
      .new_id  (next_id),
      .pc      (pc),
      .enabled (slot_en[i]),
      .id      (slot_id[i]),
      .hit     (slot_hit[i]),
      .overlap (slot_ovl[i])
    );
  end

  assign cmd_ready = (state == ST_IDLE);

  always_comb begin
    spm_current_id = '0;
    for (int i = 0; i < NB_SM; i++)
      if (slot_hit[i]) spm_current_id = slot_id[i];
    if (handling_irq) spm_current_id = ID_IRQ;
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      prev_cycle_id <= '0;
      spm_prev_id   <= '0;
    end else begin
      prev_cycle_id <= spm_current_id;
      if (prev_cycle_id != spm_current_id) spm_prev_id <= prev_cycle_id;
    end
  end

  // Response outputs are pulsed on the edge that leaves RESP.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state      <= ST_IDLE;
      op         <= OP_CREATE;
      err        <= ERR_OK;
      cid        <= '0;
      rid        <= '0;
      next_id    <= ID_W'(1);
      ts         <= '0;
      te         <= '0;
      ds         <= '0;
      de         <= '0;
      idx        <= '0;
      free_idx   <= '0;
      found_idx  <= '0;
      free_found <= 1'b0;
      found      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 3'd0;
      resp_id    <= '0;
      violation  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 3'd0;
      resp_id    <= '0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          op        <= op_e'(cmd_op);
          cid       <= cmd_id;
          ts        <= r12;
          te        <= r13;
          ds        <= r14;
          de        <= r15;
          violation <= 1'b0;
          state     <= ST_CHECK;
        end
        ST_CHECK: begin
          err        <= ERR_OK;
          rid        <= '0;
          idx        <= '0;
          free_found <= 1'b0;
          found      <= 1'b0;
          state      <= ST_SCAN;
          if (op == OP_CREATE) begin
            if (ts >= te || ds >= de || (ts < de && ds < te)) begin
              err   <= ERR_BAD_RANGE;
              state <= ST_RESP;
            end else if (next_id == ID_IRQ) begin
              err   <= ERR_EXHAUST;
              state <= ST_RESP;
            end
          end
        end
        ST_SCAN: begin
          if (op == OP_CREATE) begin
            if (slot_en[idx] && slot_ovl[idx]) err <= ERR_OVERLAP;
            if (!slot_en[idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
          end else if (slot_en[idx] && slot_id[idx] == cid && !found) begin
            found     <= 1'b1;
            found_idx <= idx;
          end
          if (idx == LAST_IDX) state <= ST_COMMIT;
          else                 idx   <= idx + 1'b1;
        end
        ST_COMMIT: begin
          if (op == OP_CREATE) begin
            if (err != ERR_OVERLAP) begin
              if (!free_found) err <= ERR_FULL;
              else begin
                rid     <= next_id;
                next_id <= next_id + 1'b1;
              end
            end
          end else if (!found) err <= ERR_NOT_FOUND;
          else                 rid <= cid;
          state <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err;
          resp_id    <= (err == ERR_OK) ? rid : '0;
          if (op == OP_CREATE && err != ERR_OK) violation <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_spm_ctrl_seq.sv
// Self-checking bench for omsp_spm_ctrl_seq: directed scenarios plus a
// randomized command stream compared against a slot-table model.
module tb_omsp_spm_ctrl_seq;

  localparam int NB = 4;
  localparam int LAT = NB + 3;

  logic        mclk = 0, puc_rst = 0, cmd_valid = 0, cmd_op = 0, handling_irq = 0, sel = 0;
  logic [15:0] cmd_id = 0, r12 = 0, r13 = 0, r14 = 0, r15 = 0, pc = 0;
  logic        cmd_ready, resp_valid, violation;
  logic [2:0]  resp_err;
  logic [15:0] resp_id, spm_current_id, spm_prev_id;
  logic        cmd_ready4, resp_valid4, violation4;
  logic [2:0]  resp_err4;
  logic [3:0]  resp_id4, cur4, prev4;

  int n_tests = 0, n_fail = 0;

  always #5 mclk = ~mclk;

  omsp_spm_ctrl_seq #(.NB_SM(NB), .ID_W(16), .ADDR_W(16)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_id(resp_id), .pc(pc),
    .handling_irq(handling_irq), .spm_current_id(spm_current_id), .spm_prev_id(spm_prev_id),
    .violation(violation));

  omsp_spm_ctrl_seq #(.NB_SM(2), .ID_W(4), .ADDR_W(16)) dut4 (
    .mclk(mclk), .puc_rst(puc_rst), .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_id(cmd_id[3:0]), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .resp_valid(resp_valid4), .resp_err(resp_err4), .resp_id(resp_id4), .pc(pc),
    .handling_irq(handling_irq), .spm_current_id(cur4), .spm_prev_id(prev4),
    .violation(violation4));

  // Reference model: a plain table of live modules and the ID counter.
  logic        m_en [NB];
  logic [15:0] m_id [NB], m_ts [NB], m_te [NB], m_ds [NB], m_de [NB];
  logic [15:0] m_next;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_en[i] = 0; m_id[i] = 0; m_ts[i] = 0; m_te[i] = 0; m_ds[i] = 0; m_de[i] = 0;
    end
    m_next = 1;
  endtask

  function automatic logic rng_ovl(input logic [15:0] as, ae, bs, be);
    return (as < be) && (bs < ae);
  endfunction

  task automatic model_create(input logic [15:0] a, b, c, d, output logic [2:0] e, output logic [15:0] id);
    int free;
    logic hit;
    id = 0; free = -1; hit = 0;
    if (a >= b || c >= d || rng_ovl(a, b, c, d)) e = 3'd1;
    else if (m_next == 16'hFFFF) e = 3'd4;
    else begin
      for (int i = 0; i < NB; i++) begin
        if (m_en[i]) hit |= rng_ovl(m_ts[i], m_te[i], a, b) || rng_ovl(m_ts[i], m_te[i], c, d) ||
                            rng_ovl(m_ds[i], m_de[i], a, b) || rng_ovl(m_ds[i], m_de[i], c, d);
        else if (free < 0) free = i;
      end
      if (hit) e = 3'd2;
      else if (free < 0) e = 3'd3;
      else begin
        e = 3'd0; id = m_next; m_next = m_next + 1;
        m_en[free] = 1; m_id[free] = id;
        m_ts[free] = a; m_te[free] = b; m_ds[free] = c; m_de[free] = d;
      end
    end
  endtask

  task automatic model_destroy(input logic [15:0] id, output logic [2:0] e, output logic [15:0] rid);
    e = 3'd5; rid = 0;
    for (int i = 0; i < NB; i++)
      if (e == 3'd5 && m_en[i] && m_id[i] == id) begin
        e = 3'd0; rid = id; m_en[i] = 0; m_id[i] = 0;
      end
  endtask

  function automatic logic [15:0] model_cur(input logic [15:0] p);
    logic [15:0] r;
    r = 0;
    for (int i = 0; i < NB; i++) if (m_en[i] && p >= m_ts[i] && p < m_te[i]) r = m_id[i];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge mclk);
    cmd_valid = 0; sel = 0; handling_irq = 0; puc_rst = 1;
    repeat (2) @(negedge mclk);
    puc_rst = 0;
    model_reset();
  endtask

  // Drives one command through the selected DUT; lat counts cycles from the accepting edge.
  task automatic do_cmd(input logic op, input logic [15:0] id, a, b, c, d,
                        output logic [2:0] e, output logic [15:0] rid, output int lat);
    int waited;
    @(negedge mclk);
    cmd_valid = 1; cmd_op = op; cmd_id = id; r12 = a; r13 = b; r14 = c; r15 = d;
    waited = 0;
    while (!(sel ? cmd_ready4 : cmd_ready) && waited < 50) begin @(negedge mclk); waited++; end
    @(posedge mclk); #1 cmd_valid = 0;
    lat = 0; e = 3'd7; rid = 16'hDEAD;
    while (lat < 60) begin
      @(posedge mclk); lat++; #1;
      if (sel ? resp_valid4 : resp_valid) begin
        e = sel ? resp_err4 : resp_err;
        rid = sel ? {12'd0, resp_id4} : resp_id;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    pc = 16'h8010;
    @(negedge mclk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %0b want 1", cmd_ready); end
    n_tests++; if (resp_valid !== 1'b0 || resp_err !== 3'd0 || resp_id !== 16'd0) begin n_fail++;
      $display("[TB] FAIL reset_resp got v=%0b e=%0d id=%0h want 0/0/0", resp_valid, resp_err, resp_id); end
    n_tests++; if (spm_prev_id !== 16'd0 || violation !== 1'b0) begin n_fail++;
      $display("[TB] FAIL reset_prev_viol got prev=%0h viol=%0b want 0/0", spm_prev_id, violation); end
    n_tests++; if (spm_current_id !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cur got %0h want 0", spm_current_id); end
  endtask

  task automatic test_create_overlap();
    logic [2:0] e; logic [15:0] rid; int lat;
    do_reset();
    do_cmd(0, 0, 16'h8000, 16'h8100, 16'h0200, 16'h0300, e, rid, lat);
    n_tests++; if (e !== 3'd0 || rid !== 16'd1 || lat != LAT) begin n_fail++;
      $display("[TB] FAIL create1 got e=%0d id=%0h lat=%0d want 0/1/%0d", e, rid, lat, LAT); end
    pc = 16'h8010; @(negedge mclk);
    n_tests++; if (spm_current_id !== 16'd1) begin n_fail++; $display("[TB] FAIL cur_after_create got %0h want 1", spm_current_id); end
    do_cmd(0, 0, 16'h80F0, 16'h8200, 16'h0400, 16'h0500, e, rid, lat);
    n_tests++; if (e !== 3'd2 || rid !== 16'd0 || lat != LAT || violation !== 1'b1) begin n_fail++;
      $display("[TB] FAIL overlap got e=%0d id=%0h lat=%0d viol=%0b want 2/0/%0d/1", e, rid, lat, violation, LAT); end
    do_cmd(0, 0, 16'h9000, 16'h9100, 16'h0600, 16'h0700, e, rid, lat);
    n_tests++; if (e !== 3'd0 || rid !== 16'd2 || violation !== 1'b0) begin n_fail++;
      $display("[TB] FAIL after_overlap got e=%0d id=%0h viol=%0b want 0/2/0", e, rid, violation); end
  endtask

  task automatic test_full_destroy();
    logic [2:0] e; logic [15:0] rid; int lat;
    do_reset();
    for (int i = 0; i < NB; i++) begin
      do_cmd(0, 0, 16'hA000 + 16'(i * 256), 16'hA080 + 16'(i * 256), 16'h1000 + 16'(i * 256), 16'h1080 + 16'(i * 256), e, rid, lat);
      n_tests++; if (e !== 3'd0 || rid !== 16'(i + 1)) begin n_fail++;
        $display("[TB] FAIL fill_%0d got e=%0d id=%0h want 0/%0h", i, e, rid, i + 1); end
    end
    do_cmd(0, 0, 16'hB000, 16'hB100, 16'h2000, 16'h2100, e, rid, lat);
    n_tests++; if (e !== 3'd3 || rid !== 16'd0 || lat != LAT) begin n_fail++;
      $display("[TB] FAIL full got e=%0d id=%0h lat=%0d want 3/0/%0d", e, rid, lat, LAT); end
    do_cmd(1, 16'd2, 0, 0, 0, 0, e, rid, lat);
    n_tests++; if (e !== 3'd0 || rid !== 16'd2 || lat != LAT) begin n_fail++;
      $display("[TB] FAIL destroy2 got e=%0d id=%0h lat=%0d want 0/2/%0d", e, rid, lat, LAT); end
    do_cmd(0, 0, 16'hB000, 16'hB100, 16'h2000, 16'h2100, e, rid, lat);
    n_tests++; if (e !== 3'd0 || rid !== 16'(NB + 1)) begin n_fail++;
      $display("[TB] FAIL retry got e=%0d id=%0h want 0/%0h", e, rid, NB + 1); end
  endtask

  task automatic test_errors();
    logic [2:0] e; logic [15:0] rid; int lat;
    do_reset();
    do_cmd(0, 0, 16'h9000, 16'h9000, 16'h0100, 16'h0200, e, rid, lat);
    n_tests++; if (e !== 3'd1 || lat != 2 || violation !== 1'b1) begin n_fail++;
      $display("[TB] FAIL bad_range got e=%0d lat=%0d viol=%0b want 1/2/1", e, lat, violation); end
    do_cmd(1, 16'h0055, 0, 0, 0, 0, e, rid, lat);
    n_tests++; if (e !== 3'd5 || rid !== 16'd0 || lat != LAT || violation !== 1'b0) begin n_fail++;
      $display("[TB] FAIL not_found got e=%0d id=%0h lat=%0d viol=%0b want 5/0/%0d/0", e, rid, lat, violation, LAT); end
  endtask

  task automatic test_prev_id();
    logic [2:0] e; logic [15:0] rid; int lat;
    do_reset();
    do_cmd(0, 0, 16'h8000, 16'h8100, 16'h0200, 16'h0300, e, rid, lat);
    pc = 16'h8010; repeat (3) @(negedge mclk);
    pc = 16'h4000; repeat (3) @(negedge mclk);
    n_tests++; if (spm_prev_id !== 16'd1) begin n_fail++; $display("[TB] FAIL prev_1 got %0h want 1", spm_prev_id); end
    pc = 16'h8010; repeat (3) @(negedge mclk);
    n_tests++; if (spm_prev_id !== 16'd0) begin n_fail++; $display("[TB] FAIL prev_0 got %0h want 0", spm_prev_id); end
    handling_irq = 1; #1;
    n_tests++; if (spm_current_id !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL cur_irq got %0h want ffff", spm_current_id); end
    @(negedge mclk); handling_irq = 0; repeat (3) @(negedge mclk);
    n_tests++; if (spm_prev_id !== 16'hFFFF || spm_current_id !== 16'd1) begin n_fail++;
      $display("[TB] FAIL prev_irq got prev=%0h cur=%0h want ffff/1", spm_prev_id, spm_current_id); end
  endtask

  task automatic test_exhaust();
    logic [2:0] e; logic [15:0] rid; int lat; int bad;
    do_reset();
    sel = 1; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      do_cmd(0, 0, 16'hA000, 16'hA100, 16'h0100, 16'h0200, e, rid, lat);
      if (e !== 3'd0 || rid !== 16'(k)) bad++;
      do_cmd(1, 16'(k), 0, 0, 0, 0, e, rid, lat);
      if (e !== 3'd0 || rid !== 16'(k)) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("[TB] FAIL id_sequence got %0d bad responses want 0", bad); end
    for (int j = 0; j < 2; j++) begin
      do_cmd(0, 0, 16'hA000, 16'hA100, 16'h0100, 16'h0200, e, rid, lat);
      n_tests++; if (e !== 3'd4 || rid !== 16'd0 || lat != 2) begin n_fail++;
        $display("[TB] FAIL exhaust_%0d got e=%0d id=%0h lat=%0d want 4/0/2", j, e, rid, lat); end
    end
    sel = 0;
  endtask

  task automatic test_reset_mid_scan();
    logic [2:0] e; logic [15:0] rid; int lat; int seen;
    do_reset();
    @(negedge mclk);
    cmd_valid = 1; cmd_op = 0; r12 = 16'h8000; r13 = 16'h8100; r14 = 16'h0200; r15 = 16'h0300;
    @(posedge mclk); #1 cmd_valid = 0;
    repeat (3) @(posedge mclk);
    @(negedge mclk); puc_rst = 1; @(negedge mclk); puc_rst = 0;
    seen = 0;
    repeat (NB + 6) begin @(posedge mclk); #1 if (resp_valid) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("[TB] FAIL abort_no_resp got %0d pulses want 0", seen); end
    pc = 16'h8010; @(negedge mclk);
    n_tests++; if (spm_current_id !== 16'd0) begin n_fail++; $display("[TB] FAIL abort_table got %0h want 0", spm_current_id); end
    do_cmd(0, 0, 16'h8000, 16'h8100, 16'h0200, 16'h0300, e, rid, lat);
    n_tests++; if (e !== 3'd0 || rid !== 16'd1) begin n_fail++;
      $display("[TB] FAIL abort_recreate got e=%0d id=%0h want 0/1", e, rid); end
  endtask

  task automatic test_random();
    logic [2:0] e, xe; logic [15:0] rid, xid, a, b, c, d, id; int lat, xlat, k;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom_range(0, 16'hFE00)); b = a + 16'($urandom_range(0, 16'h0600));
        c = 16'($urandom_range(0, 16'hFE00)); d = c + 16'($urandom_range(0, 16'h0600));
        model_create(a, b, c, d, xe, xid);
        do_cmd(0, 0, a, b, c, d, e, rid, lat);
      end else begin
        k = $urandom_range(0, NB - 1);
        id = ($urandom_range(0, 3) != 0) ? m_id[k] : 16'($urandom_range(0, 20));
        model_destroy(id, xe, xid);
        do_cmd(1, id, 0, 0, 0, 0, e, rid, lat);
      end
      xlat = (xe == 3'd1 || xe == 3'd4) ? 2 : LAT;
      n_tests++; if (e !== xe || rid !== xid || lat != xlat) begin n_fail++;
        $display("[TB] FAIL rand_cmd_%0d got e=%0d id=%0h lat=%0d want %0d/%0h/%0d", n, e, rid, lat, xe, xid, xlat); end
      k = $urandom_range(0, NB - 1);
      pc = (m_en[k] && $urandom_range(0, 1) == 1) ? m_ts[k] + 16'((m_te[k] - m_ts[k]) / 2) : 16'($urandom);
      @(negedge mclk);
      n_tests++; if (spm_current_id !== model_cur(pc)) begin n_fail++;
        $display("[TB] FAIL rand_cur_%0d pc=%0h got %0h want %0h", n, pc, spm_current_id, model_cur(pc)); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_create_overlap();
    test_full_destroy();
    test_errors();
    test_prev_id();
    test_reset_mid_scan();
    test_random();
    test_exhaust();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
